// File: rtl/vc_pkg.sv
// Shared types and constants for the traffic-class / virtual-channel demux path.
package vc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STALL
   } state_e;

   localparam int unsigned VC_BIT_DEFAULT = 4;

   localparam logic VC0 = 1'b0;
   localparam logic VC1 = 1'b1;

endpackage

// File: rtl/vc_counter.sv
// Per-VC wrapping word counter with synchronous clear.
module vc_counter #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/vc_demux.sv
// Pops words from Main and steers each to VC0/VC1 by a class bit, holding one word under almost-full.
module vc_demux
   import vc_pkg::*;
#(
   parameter int unsigned BW     = 6,
   parameter int unsigned VC_BIT = VC_BIT_DEFAULT,
   parameter int unsigned CNT_W  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             active,
   input  logic             main_empty,
   input  logic [BW-1:0]    main_data,
   output logic             main_rd,
   input  logic             vc0_almost_full,
   input  logic             vc1_almost_full,
   output logic             vc0_wr,
   output logic             vc1_wr,
   output logic [BW-1:0]    vc_data,
   output logic [CNT_W-1:0] cnt_vc0,
   output logic [CNT_W-1:0] cnt_vc1,
   output logic             idle
);

   state_e        state_q, state_d;
   logic          rd_pending_q, rd_pending_d;
   logic          hold_valid_q, hold_valid_d;
   logic [BW-1:0] hold_data_q, hold_data_d;
   logic          vc0_wr_q, vc0_wr_d;
   logic          vc1_wr_q, vc1_wr_d;
   logic [BW-1:0] vc_data_q, vc_data_d;
   logic          idle_q, idle_d;

   logic arr_af;
   logic hold_af;
   logic main_rd_c;

   assign arr_af  = (main_data[VC_BIT] == VC1)   ? vc1_almost_full : vc0_almost_full;
   assign hold_af = (hold_data_q[VC_BIT] == VC1) ? vc1_almost_full : vc0_almost_full;

   // A pending arrival bound for a full VC blocks the pop in the same cycle, so STALL starts with nothing in flight.
   assign main_rd_c = !reset && active && !main_empty && (state_q != ST_STALL)
                      && !(rd_pending_q && arr_af);

   always_comb begin
      state_d      = state_q;
      rd_pending_d = main_rd_c;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      vc0_wr_d     = 1'b0;
      vc1_wr_d     = 1'b0;
      vc_data_d    = vc_data_q;
      idle_d       = (state_q == ST_IDLE) && !rd_pending_q && !hold_valid_q;

      unique case (state_q)
         ST_IDLE: begin
            if (active && !main_empty) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (rd_pending_q) begin
               if (arr_af) begin
                  hold_valid_d = 1'b1;
                  hold_data_d  = main_data;
                  state_d      = ST_STALL;
               end else begin
                  vc0_wr_d  = (main_data[VC_BIT] == VC0);
                  vc1_wr_d  = (main_data[VC_BIT] == VC1);
                  vc_data_d = main_data;
               end
            end else if (!main_rd_c && !hold_valid_q) begin
               state_d = ST_IDLE;
            end
         end
         ST_STALL: begin
            if (!hold_af) begin
               vc0_wr_d     = (hold_data_q[VC_BIT] == VC0);
               vc1_wr_d     = (hold_data_q[VC_BIT] == VC1);
               vc_data_d    = hold_data_q;
               hold_valid_d = 1'b0;
               state_d      = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rd_pending_q <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         vc0_wr_q     <= 1'b0;
         vc1_wr_q     <= 1'b0;
         vc_data_q    <= '0;
         idle_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         rd_pending_q <= rd_pending_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         vc0_wr_q     <= vc0_wr_d;
         vc1_wr_q     <= vc1_wr_d;
         vc_data_q    <= vc_data_d;
         idle_q       <= idle_d;
      end
   end

   vc_counter #(.CNT_W(CNT_W)) u_cnt_vc0 (
      .clk   (clk),
      .reset (reset),
      .inc   (vc0_wr_d),
      .count (cnt_vc0)
   );

   vc_counter #(.CNT_W(CNT_W)) u_cnt_vc1 (
      .clk   (clk),
      .reset (reset),
      .inc   (vc1_wr_d),
      .count (cnt_vc1)
   );

   assign main_rd = main_rd_c;
   assign vc0_wr  = vc0_wr_q;
   assign vc1_wr  = vc1_wr_q;
   assign vc_data = vc_data_q;
   assign idle    = idle_q;

endmodule

// File: tb/tb_vc_demux.sv
// Directed bench for vc_demux with a behavioural Main FIFO and a write/pop log.
module tb_vc_demux;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       active = 1'b0;
   logic       main_empty;
   logic [5:0] main_data = '0;
   logic       main_rd;
   logic       vc0_almost_full = 1'b0;
   logic       vc1_almost_full = 1'b0;
   logic       vc0_wr, vc1_wr;
   logic [5:0] vc_data;
   logic [4:0] cnt_vc0, cnt_vc1;
   logic       idle;

   vc_demux #(.BW(6), .VC_BIT(4), .CNT_W(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .active          (active),
      .main_empty      (main_empty),
      .main_data       (main_data),
      .main_rd         (main_rd),
      .vc0_almost_full (vc0_almost_full),
      .vc1_almost_full (vc1_almost_full),
      .vc0_wr          (vc0_wr),
      .vc1_wr          (vc1_wr),
      .vc_data         (vc_data),
      .cnt_vc0         (cnt_vc0),
      .cnt_vc1         (cnt_vc1),
      .idle            (idle)
   );

   always #5 clk = ~clk;

   // Main FIFO model: data appears the cycle after a pop
   logic [5:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign main_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (main_rd) begin
         main_data <= mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   typedef struct {
      logic       vc;
      logic [5:0] data;
      int         cyc;
   } wr_t;

   int  cyc = 0;
   int  both_cnt = 0;
   wr_t wr_log [$];
   int  pop_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      wr_t e;
      if (vc0_wr && vc1_wr) both_cnt++;
      if (main_rd) pop_cyc.push_back(cyc);
      if (vc0_wr || vc1_wr) begin
         e.vc   = vc1_wr;
         e.data = vc_data;
         e.cyc  = cyc;
         wr_log.push_back(e);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic push(input logic [5:0] w);
      mem[wr_ptr % 64] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset  = 1'b1;
      active = 1'b1;
      push(6'h00); push(6'h10); push(6'h05); push(6'h1F);
      repeat (2) @(negedge clk);
      n_checks++; if (main_rd !== 1'b0) begin n_fail++; $display("FAIL reset_main_rd: got %b expected 0", main_rd); end
      n_checks++; if (vc0_wr !== 1'b0) begin n_fail++; $display("FAIL reset_vc0_wr: got %b expected 0", vc0_wr); end
      n_checks++; if (vc1_wr !== 1'b0) begin n_fail++; $display("FAIL reset_vc1_wr: got %b expected 0", vc1_wr); end
      n_checks++; if (vc_data !== 6'h00) begin n_fail++; $display("FAIL reset_vc_data: got %h expected 00", vc_data); end
      n_checks++; if (cnt_vc0 !== 5'd0) begin n_fail++; $display("FAIL reset_cnt_vc0: got %0d expected 0", cnt_vc0); end
      n_checks++; if (cnt_vc1 !== 5'd0) begin n_fail++; $display("FAIL reset_cnt_vc1: got %0d expected 0", cnt_vc1); end
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
   endtask

   task automatic test_stream;
      logic [5:0] exp_d [4];
      logic       exp_v [4];
      exp_d[0] = 6'h00; exp_v[0] = 1'b0;
      exp_d[1] = 6'h10; exp_v[1] = 1'b1;
      exp_d[2] = 6'h05; exp_v[2] = 1'b0;
      exp_d[3] = 6'h1F; exp_v[3] = 1'b1;
      wr_log.delete();
      pop_cyc.delete();
      reset = 1'b0;
      for (int k = 0; k < 20 && wr_log.size() < 4; k++) @(negedge clk);
      n_checks++;
      if (wr_log.size() != 4 || pop_cyc.size() != 4) begin
         n_fail++;
         $display("FAIL stream_count: got %0d writes %0d pops expected 4 and 4", wr_log.size(), pop_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++; if (wr_log[i].data !== exp_d[i]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, wr_log[i].data, exp_d[i]); end
            n_checks++; if (wr_log[i].vc !== exp_v[i]) begin n_fail++; $display("FAIL stream_vc[%0d]: got %b expected %b", i, wr_log[i].vc, exp_v[i]); end
            n_checks++; if (wr_log[i].cyc - pop_cyc[i] != 2) begin n_fail++; $display("FAIL stream_latency[%0d]: got %0d expected 2", i, wr_log[i].cyc - pop_cyc[i]); end
         end
      end
      repeat (2) @(negedge clk);
      n_checks++; if (cnt_vc0 !== 5'd2) begin n_fail++; $display("FAIL stream_cnt_vc0: got %0d expected 2", cnt_vc0); end
      n_checks++; if (cnt_vc1 !== 5'd2) begin n_fail++; $display("FAIL stream_cnt_vc1: got %0d expected 2", cnt_vc1); end
   endtask

   task automatic test_stall;
      repeat (3) @(negedge clk);
      vc1_almost_full = 1'b1;
      push(6'h12); push(6'h03);
      #1;
      n_checks++; if (main_rd !== 1'b1) begin n_fail++; $display("FAIL stall_first_pop: got %b expected 1", main_rd); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (main_rd !== 1'b0) begin n_fail++; $display("FAIL stall_main_rd[%0d]: got %b expected 0", i, main_rd); end
         n_checks++; if ((vc0_wr | vc1_wr) !== 1'b0) begin n_fail++; $display("FAIL stall_no_write[%0d]: got %b%b expected 00", i, vc0_wr, vc1_wr); end
      end
      vc1_almost_full = 1'b0;
      @(negedge clk);
      n_checks++; if (vc1_wr !== 1'b1 || vc0_wr !== 1'b0) begin n_fail++; $display("FAIL stall_release_wr: got vc0=%b vc1=%b expected vc0=0 vc1=1", vc0_wr, vc1_wr); end
      n_checks++; if (vc_data !== 6'h12) begin n_fail++; $display("FAIL stall_release_data: got %h expected 12", vc_data); end
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (vc0_wr !== 1'b1 || vc_data !== 6'h03) begin n_fail++; $display("FAIL stall_resume: got vc0=%b data=%h expected vc0=1 data=03", vc0_wr, vc_data); end
   endtask

   task automatic test_head_of_line;
      repeat (3) @(negedge clk);
      vc1_almost_full = 1'b1;
      push(6'h11); push(6'h02);
      #1;
      n_checks++; if (main_rd !== 1'b1) begin n_fail++; $display("FAIL hol_first_pop: got %b expected 1", main_rd); end
      wr_log.delete();
      repeat (4) @(negedge clk);
      n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL hol_blocked: got %0d writes expected 0", wr_log.size()); end
      vc1_almost_full = 1'b0;
      for (int k = 0; k < 10 && wr_log.size() < 2; k++) @(negedge clk);
      n_checks++;
      if (wr_log.size() != 2) begin
         n_fail++; $display("FAIL hol_count: got %0d writes expected 2", wr_log.size());
      end else begin
         n_checks++; if (wr_log[0].vc !== 1'b1 || wr_log[0].data !== 6'h11) begin n_fail++; $display("FAIL hol_first: got vc%0d %h expected vc1 11", wr_log[0].vc, wr_log[0].data); end
         n_checks++; if (wr_log[1].vc !== 1'b0 || wr_log[1].data !== 6'h02) begin n_fail++; $display("FAIL hol_second: got vc%0d %h expected vc0 02", wr_log[1].vc, wr_log[1].data); end
      end
   endtask

   task automatic test_drop_active;
      repeat (3) @(negedge clk);
      push(6'h07); push(6'h08);
      #1;
      n_checks++; if (main_rd !== 1'b1) begin n_fail++; $display("FAIL drop_first_pop: got %b expected 1", main_rd); end
      @(posedge clk);
      #1 active = 1'b0;
      @(negedge clk);
      n_checks++; if (main_rd !== 1'b0) begin n_fail++; $display("FAIL drop_main_rd_a: got %b expected 0", main_rd); end
      @(negedge clk);
      n_checks++; if (vc0_wr !== 1'b1 || vc_data !== 6'h07) begin n_fail++; $display("FAIL drop_inflight: got vc0=%b data=%h expected vc0=1 data=07", vc0_wr, vc_data); end
      n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL drop_idle_b: got %b expected 0", idle); end
      @(negedge clk);
      n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL drop_idle_c: got %b expected 0", idle); end
      n_checks++; if (main_rd !== 1'b0 || vc0_wr !== 1'b0) begin n_fail++; $display("FAIL drop_quiet: got rd=%b wr=%b expected 0 0", main_rd, vc0_wr); end
      @(negedge clk);
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL drop_idle_d: got %b expected 1", idle); end
      wr_log.delete();
      active = 1'b1;
      for (int k = 0; k < 10 && wr_log.size() < 1; k++) @(negedge clk);
      n_checks++; if (wr_log.size() != 1 || wr_log[0].data !== 6'h08) begin n_fail++; $display("FAIL drop_drain: got %0d writes expected one write of 08", wr_log.size()); end
   endtask

   task automatic test_reset_stall;
      repeat (3) @(negedge clk);
      vc1_almost_full = 1'b1;
      push(6'h13);
      #1;
      n_checks++; if (main_rd !== 1'b1) begin n_fail++; $display("FAIL rststall_pop: got %b expected 1", main_rd); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wr_log.delete();
      @(negedge clk);
      n_checks++; if (main_rd !== 1'b0) begin n_fail++; $display("FAIL rststall_main_rd: got %b expected 0", main_rd); end
      n_checks++; if (vc0_wr !== 1'b0 || vc1_wr !== 1'b0) begin n_fail++; $display("FAIL rststall_wr: got %b%b expected 00", vc0_wr, vc1_wr); end
      n_checks++; if (vc_data !== 6'h00) begin n_fail++; $display("FAIL rststall_vc_data: got %h expected 00", vc_data); end
      n_checks++; if (cnt_vc0 !== 5'd0 || cnt_vc1 !== 5'd0) begin n_fail++; $display("FAIL rststall_cnt: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rststall_idle: got %b expected 1", idle); end
      vc1_almost_full = 1'b0;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL rststall_discard: got %0d writes expected 0", wr_log.size()); end
   endtask

   task automatic test_wrap;
      int bad;
      repeat (2) @(negedge clk);
      wr_log.delete();
      for (int i = 0; i < 33; i++) push(6'((i % 16) | 32));
      for (int k = 0; k < 200 && wr_log.size() < 33; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      n_checks++; if (wr_log.size() != 33) begin n_fail++; $display("FAIL wrap_count: got %0d writes expected 33", wr_log.size()); end
      bad = 0;
      for (int i = 0; i < wr_log.size(); i++)
         if (wr_log[i].vc !== 1'b0 || wr_log[i].data !== 6'((i % 16) | 32)) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_order: got %0d bad words expected 0", bad); end
      n_checks++; if (cnt_vc0 !== 5'd1) begin n_fail++; $display("FAIL wrap_cnt_vc0: got %0d expected 1", cnt_vc0); end
      n_checks++; if (cnt_vc1 !== 5'd0) begin n_fail++; $display("FAIL wrap_cnt_vc1: got %0d expected 0", cnt_vc1); end
   endtask

   task automatic test_exclusive;
      n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL exclusive_wr: got %0d dual-write cycles expected 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_head_of_line();
      test_drop_active();
      test_reset_stall();
      test_wrap();
      test_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
